// File: rtl/id_stage_ctrl.sv
// id_stage_ctrl -- decode-stage controller between fetch and execute.
//
// Accepts fetched instructions over a valid/ready handshake, decodes the
// opcode into the immediate format and the main control bits, and holds
// up to two instructions (output register + skid register).
// if_ready is a register, so there is no combinational path from id_ready
// back to fetch.
//
// Optional build macro: ID_ILLEGAL_HALT_EN
//   defined   : unknown opcodes are passed on with id_illegal=1.
//               Consuming that entry parks the controller in HALT until a
//               flush or reset arrives.
//   undefined : id_illegal is tied to 0.
//               Unknown opcodes flow through as NOPs with no control bits set.
//
// Ports:
//   clk, rst          clock, async active-high reset
//   flush             synchronous squash of all buffered entries
//   if_valid/if_ready fetch handshake
//   if_inst, if_pc    fetched word and its PC
//   id_valid/id_ready execute handshake
//   id_inst, id_pc    buffered word and PC (NOP / 0 while empty)
//   id_imm_type       000 I, 001 S, 010 B, 011 U, 100 J
//   id_use_imm, id_reg_write, id_mem_read, id_mem_write, id_branch, id_jump
//   id_illegal        unsupported opcode (optional feature)
module id_stage_ctrl #(
    parameter int          PC_W     = 32,
    parameter logic [31:0] NOP_INST = 32'h00000013
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            if_valid,
    output logic            if_ready,
    input  logic [31:0]     if_inst,
    input  logic [PC_W-1:0] if_pc,
    output logic            id_valid,
    input  logic            id_ready,
    output logic [31:0]     id_inst,
    output logic [PC_W-1:0] id_pc,
    output logic [2:0]      id_imm_type,
    output logic            id_use_imm,
    output logic            id_reg_write,
    output logic            id_mem_read,
    output logic            id_mem_write,
    output logic            id_branch,
    output logic            id_jump,
    output logic            id_illegal
);

    typedef struct packed {
        logic [2:0] imm_type;
        logic       use_imm;
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic       branch;
        logic       jump;
`ifdef ID_ILLEGAL_HALT_EN
        logic       illegal;
`endif
    } ctl_t;

    typedef struct packed {
        logic [31:0]     inst;
        logic [PC_W-1:0] pc;
        ctl_t            ctl;
    } entry_t;

`ifdef ID_ILLEGAL_HALT_EN
    typedef enum logic [1:0] {EMPTY, ONE, TWO, HALT} state_t;
`else
    typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;
`endif

    function automatic ctl_t decode(input logic [6:0] opc);
        ctl_t c;
        c = '0;
        case (opc)
            7'b0110111,
            7'b0010111: begin c.imm_type = 3'b011; c.use_imm = 1'b1; c.reg_write = 1'b1; end
            7'b1101111: begin c.imm_type = 3'b100; c.use_imm = 1'b1; c.reg_write = 1'b1; c.jump = 1'b1; end
            7'b1100111: begin c.use_imm = 1'b1; c.reg_write = 1'b1; c.jump = 1'b1; end
            7'b1100011: begin c.imm_type = 3'b010; c.branch = 1'b1; end
            7'b0000011: begin c.use_imm = 1'b1; c.reg_write = 1'b1; c.mem_read = 1'b1; end
            7'b0100011: begin c.imm_type = 3'b001; c.use_imm = 1'b1; c.mem_write = 1'b1; end
            7'b0010011: begin c.use_imm = 1'b1; c.reg_write = 1'b1; end
            7'b0110011: c.reg_write = 1'b1;
            7'b0001111,
            7'b1110011: ;
`ifdef ID_ILLEGAL_HALT_EN
            default:    c.illegal = 1'b1;
`else
            default:    ;
`endif
        endcase
        return c;
    endfunction

    function automatic entry_t nop_entry();
        entry_t e;
        e      = '0;
        e.inst = NOP_INST;
        return e;
    endfunction

    state_t state;
    entry_t out_q, skid_q;
    entry_t in_e;

    // Decoded at acceptance; the control bits travel with the entry.
    always_comb begin
        in_e      = '0;
        in_e.inst = if_inst;
        in_e.pc   = if_pc;
        in_e.ctl  = decode(if_inst[6:0]);
    end

    logic accept, drain;
    assign accept = if_valid && if_ready;
    assign drain  = id_valid && id_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= EMPTY;
            id_valid <= 1'b0;
            if_ready <= 1'b1;
            out_q    <= nop_entry();
            skid_q   <= nop_entry();
        end else if (flush) begin
            state    <= EMPTY;
            id_valid <= 1'b0;
            if_ready <= 1'b1;
            out_q    <= nop_entry();
            skid_q   <= nop_entry();
        end else begin
            case (state)
                EMPTY: begin
                    if (accept) begin
                        out_q    <= in_e;
                        id_valid <= 1'b1;
                        state    <= ONE;
                    end
                end
                ONE: begin
`ifdef ID_ILLEGAL_HALT_EN
                    // Consuming an illegal entry stops the stream; any
                    // instruction arriving in the same cycle is dropped.
                    if (drain && out_q.ctl.illegal) begin
                        out_q    <= nop_entry();
                        id_valid <= 1'b0;
                        if_ready <= 1'b0;
                        state    <= HALT;
                    end else
`endif
                    if (accept && drain) begin
                        out_q <= in_e;
                    end else if (accept) begin
                        skid_q   <= in_e;
                        if_ready <= 1'b0;
                        state    <= TWO;
                    end else if (drain) begin
                        out_q    <= nop_entry();
                        id_valid <= 1'b0;
                        state    <= EMPTY;
                    end
                end
                TWO: begin
                    // if_ready is low here, so no accept can happen.
`ifdef ID_ILLEGAL_HALT_EN
                    if (drain && out_q.ctl.illegal) begin
                        out_q    <= nop_entry();
                        skid_q   <= nop_entry();
                        id_valid <= 1'b0;
                        state    <= HALT;
                    end else
`endif
                    if (drain) begin
                        out_q    <= skid_q;
                        skid_q   <= nop_entry();
                        if_ready <= 1'b1;
                        state    <= ONE;
                    end
                end
                default: ; // HALT: only flush or reset leaves
            endcase
        end
    end

    assign id_inst      = out_q.inst;
    assign id_pc        = out_q.pc;
    assign id_imm_type  = out_q.ctl.imm_type;
    assign id_use_imm   = out_q.ctl.use_imm;
    assign id_reg_write = out_q.ctl.reg_write;
    assign id_mem_read  = out_q.ctl.mem_read;
    assign id_mem_write = out_q.ctl.mem_write;
    assign id_branch    = out_q.ctl.branch;
    assign id_jump      = out_q.ctl.jump;
`ifdef ID_ILLEGAL_HALT_EN
    assign id_illegal   = out_q.ctl.illegal;
`else
    assign id_illegal   = 1'b0;
`endif

endmodule
